accumulator_register: RTL and testbench



---
 rtl/accumulator_register_pkg.sv | 12 +
 rtl/accumulator_register_n_bit_register.sv | 20 ++
 rtl/accumulator_register.sv | 113 +++++++++++
 tb/tb_accumulator_register.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/accumulator_register_pkg.sv
// Shared definitions for the MAC accumulator: mode encodings decoded from the 2-bit mode input.
// Optional build macro used by the top: ACCUMULATOR_SATURATE_EN.
package accumulator_register_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_ACC   = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

endpackage

// File: rtl/accumulator_register_n_bit_register.sv
// WIDTH-bit storage cell with update enable and synchronous active-high reset.
module n_bit_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/accumulator_register.sv
// Signed accumulating register (hold/load/accumulate/clear) with sticky overflow and saturating term count.
// Build option: define ACCUMULATOR_SATURATE_EN to clamp out on overflow instead of wrapping.
module accumulator_register
    import accumulator_register_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IN_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [WIDTH-1:0]     out,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]     in_ext;
    logic [WIDTH-1:0]     sum;
    logic                 acc_ovf;
    logic [WIDTH-1:0]     acc_value;
    logic                 out_en;
    logic [WIDTH-1:0]     out_next;
    logic                 overflow_reg;
    logic [CNT_WIDTH-1:0] count_reg;
    mode_t                mode_sel;

    assign mode_sel = mode_t'(mode);
    assign in_ext   = WIDTH'($signed(in));
    assign sum      = out + in_ext;

    // Signed overflow: addends agree in sign but the sum does not.
    assign acc_ovf = (out[WIDTH-1] == in_ext[WIDTH-1]) && (sum[WIDTH-1] != out[WIDTH-1]);

`ifdef ACCUMULATOR_SATURATE_EN
    // On overflow the addends share a sign, so the old accumulator sign picks the clamp direction.
    assign acc_value = acc_ovf ? (out[WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
`else
    assign acc_value = sum;
`endif

    always_comb begin
        out_en   = 1'b0;
        out_next = out;
        if (enable) begin
            case (mode_sel)
                MODE_LOAD: begin
                    out_en   = 1'b1;
                    out_next = in_ext;
                end
                MODE_ACC: begin
                    out_en   = 1'b1;
                    out_next = acc_value;
                end
                MODE_CLEAR: begin
                    out_en   = 1'b1;
                    out_next = '0;
                end
                default: begin
                    out_en   = 1'b0;
                    out_next = out;
                end
            endcase
        end
    end

    n_bit_register #(
        .WIDTH(WIDTH)
    ) u_acc_reg (
        .clk    (clk),
        .reset  (reset),
        .enable (out_en),
        .d      (out_next),
        .q      (out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
            count_reg    <= '0;
        end else if (enable) begin
            case (mode_sel)
                MODE_LOAD: begin
                    overflow_reg <= 1'b0;
                    count_reg    <= CNT_WIDTH'(1);
                end
                MODE_ACC: begin
                    overflow_reg <= overflow_reg | acc_ovf;
                    if (count_reg != '1) begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                MODE_CLEAR: begin
                    overflow_reg <= 1'b0;
                    count_reg    <= '0;
                end
                default: begin
                    overflow_reg <= overflow_reg;
                    count_reg    <= count_reg;
                end
            endcase
        end
    end

    assign overflow = overflow_reg;
    assign count    = count_reg;

endmodule

// File: tb/tb_accumulator_register.sv
// Directed bench for accumulator_register: reference model feeds a scoreboard queue, popped one cycle later.
module tb_accumulator_register;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_LOAD  = 2'b01;
    localparam logic [1:0] M_ACC   = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = M_HOLD;
    logic [7:0]  in = 8'h00;
    logic [15:0] out;
    logic        overflow;
    logic [7:0]  count;

    typedef struct {
        logic [15:0] o;
        logic        ov;
        logic [7:0]  c;
    } exp_t;

    exp_t q[$];
    int   m_val = 0;
    logic m_ov  = 1'b0;
    int   m_cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    accumulator_register #(
        .WIDTH(16),
        .IN_WIDTH(8),
        .CNT_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .in       (in),
        .out      (out),
        .overflow (overflow),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model uses wide integer arithmetic and range tests for overflow.
    task automatic model(input logic r, input logic e, input logic [1:0] m, input logic [7:0] d);
        int s;
        if (r) begin
            m_val = 0; m_ov = 1'b0; m_cnt = 0;
        end else if (e) begin
            case (m)
                M_LOAD:  begin m_val = int'($signed(d)); m_ov = 1'b0; m_cnt = 1; end
                M_CLEAR: begin m_val = 0; m_ov = 1'b0; m_cnt = 0; end
                M_ACC: begin
                    s = m_val + int'($signed(d));
                    if (s > 32767 || s < -32768) begin
                        m_ov = 1'b1;
`ifdef ACCUMULATOR_SATURATE_EN
                        m_val = (s > 0) ? 32767 : -32768;
`else
                        m_val = int'($signed(16'(s)));
`endif
                    end else begin
                        m_val = s;
                    end
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] d,
                        input bit verbose);
        exp_t x;
        reset = r; enable = e; mode = m; in = d;
        model(r, e, m, d);
        x.o = 16'(m_val); x.ov = m_ov; x.c = 8'(m_cnt);
        q.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        checks++;
        assert (q.size() == 1) else begin
            errors++;
            $error("FAIL scoreboard_depth observed=%0d expected=1", q.size());
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sb_out", 32'(out), 32'(x.o));
            chk("sb_overflow", 32'(overflow), 32'(x.ov));
            chk("sb_count", 32'(count), 32'(x.c));
        end
        if (verbose)
            $display("step %0d: reset=%0b en=%0b mode=%0d in=%h -> out=%h ov=%0b count=%0d",
                     step_no, r, e, m, d, out, overflow, count);
    endtask

    initial begin
        // Power-up reset
        model(1'b1, 1'b0, M_HOLD, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset wins over enable/load
        step(1, 1, M_LOAD, 8'h7F, 1);
        chk("reset_out", 32'(out), 32'h0000);
        chk("reset_overflow", 32'(overflow), 32'h0);
        chk("reset_count", 32'(count), 32'h0);

        // Sign extension and accumulation
        step(0, 1, M_LOAD, 8'hF6, 1);
        chk("sext_load_out", 32'(out), 32'hFFF6);
        chk("sext_load_count", 32'(count), 32'h1);
        step(0, 1, M_ACC, 8'h05, 1);
        chk("acc_out", 32'(out), 32'hFFFB);
        chk("acc_count", 32'(count), 32'h2);
        step(0, 1, M_HOLD, 8'h33, 1);
        chk("hold_mode_out", 32'(out), 32'hFFFB);

        // Positive overflow and count saturation: 127 + 257*127 = 32766
        step(0, 1, M_LOAD, 8'h7F, 1);
        for (int i = 0; i < 257; i++) step(0, 1, M_ACC, 8'h7F, 0);
        $display("step %0d: after 257 accumulates out=%h ov=%0b count=%0d", step_no, out, overflow, count);
        chk("presat_out", 32'(out), 32'h7FFE);
        chk("presat_overflow", 32'(overflow), 32'h0);
        chk("count_saturated", 32'(count), 32'd255);
        step(0, 1, M_ACC, 8'h7F, 1);
`ifdef ACCUMULATOR_SATURATE_EN
        chk("pos_ovf_out", 32'(out), 32'h7FFF);
`else
        chk("pos_ovf_out", 32'(out), 32'h807D);
`endif
        chk("pos_ovf_flag", 32'(overflow), 32'h1);
        chk("count_no_wrap", 32'(count), 32'd255);
        step(0, 1, M_ACC, 8'h00, 1);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // Clear after overflow, then negative load
        step(0, 1, M_CLEAR, 8'h55, 1);
        chk("clear_out", 32'(out), 32'h0000);
        chk("clear_overflow", 32'(overflow), 32'h0);
        chk("clear_count", 32'(count), 32'h0);
        step(0, 1, M_LOAD, 8'h80, 1);
        chk("neg_load_out", 32'(out), 32'hFF80);

        // Negative overflow: -128*256 = -32768 fits, one more overflows
        for (int i = 0; i < 255; i++) step(0, 1, M_ACC, 8'h80, 0);
        chk("neg_edge_out", 32'(out), 32'h8000);
        chk("neg_edge_overflow", 32'(overflow), 32'h0);
        step(0, 1, M_ACC, 8'h80, 1);
`ifdef ACCUMULATOR_SATURATE_EN
        chk("neg_ovf_out", 32'(out), 32'h8000);
`else
        chk("neg_ovf_out", 32'(out), 32'h7F80);
`endif
        chk("neg_ovf_flag", 32'(overflow), 32'h1);

        // Enable low holds everything; load clears sticky flag
        step(0, 1, M_LOAD, 8'h10, 1);
        chk("load_clears_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, M_ACC, 8'h01, 1);
        chk("disabled_out", 32'(out), 32'h0010);
        chk("disabled_count", 32'(count), 32'h1);

        // Reset mid-stream aborts the sum
        for (int i = 0; i < 3; i++) step(0, 1, M_ACC, 8'h02, 1);
        chk("stream_out", 32'(out), 32'h0016);
        step(1, 1, M_ACC, 8'h02, 1);
        chk("midreset_out", 32'(out), 32'h0000);
        chk("midreset_count", 32'(count), 32'h0);
        chk("midreset_overflow", 32'(overflow), 32'h0);
        step(0, 1, M_ACC, 8'h03, 1);
        chk("resume_out", 32'(out), 32'h0003);
        chk("resume_count", 32'(count), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
